// File: rtl/read_scheduler_pkg.sv
// Shared types and defaults for the read scheduler.
// A base is one BASE_LEN-bit symbol on the shared datapath.
package proj_pkg;
    localparam int BASE_LEN         = 8;
    localparam int DEF_NUM_SRC      = 4;
    localparam int DEF_MAX_READ_LEN = 256;

    // A single source still needs a one-bit id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SRC_ID_W = id_w(DEF_NUM_SRC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } sched_state_t;
endpackage

// File: rtl/read_scheduler_if.sv
// Source-side and datapath-side signals of the read scheduler.
// slave is the scheduler; master is whatever drives sources and the datapath.
interface read_scheduler_if #(
    parameter int NUM_SRC      = proj_pkg::DEF_NUM_SRC,
    parameter int MAX_READ_LEN = proj_pkg::DEF_MAX_READ_LEN
);
    localparam int ID_W  = proj_pkg::id_w(NUM_SRC);
    localparam int LEN_W = $clog2(MAX_READ_LEN + 1);

    logic [NUM_SRC-1:0]                        src_valid;
    logic [NUM_SRC-1:0][proj_pkg::BASE_LEN-1:0] src_data;
    logic [NUM_SRC-1:0]                        src_last;
    logic [NUM_SRC-1:0]                        src_ready;
    logic [proj_pkg::BASE_LEN-1:0]             dp_in_data;
    logic                                      dp_in_valid;
    logic                                      dp_wait;
    logic [ID_W-1:0]                           grant_id;
    logic                                      busy;
    logic                                      read_done;
    logic [ID_W-1:0]                           read_src;
    logic [LEN_W-1:0]                          read_len;
    logic                                      err_overflow;

    modport slave (
        input  src_valid, src_data, src_last, dp_wait,
        output src_ready, dp_in_data, dp_in_valid, grant_id, busy,
               read_done, read_src, read_len, err_overflow
    );

    modport master (
        output src_valid, src_data, src_last, dp_wait,
        input  src_ready, dp_in_data, dp_in_valid, grant_id, busy,
               read_done, read_src, read_len, err_overflow
    );
endinterface

// File: rtl/read_scheduler_rr_arbiter.sv
// Round-robin pick: searches upward from i_ptr+1, wrapping, i_ptr itself last.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            w_cand = ID_W'((int'(i_ptr) + i) % NUM_SRC);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end
endmodule

// File: rtl/read_scheduler.sv
// Shares one datapath between NUM_SRC read sources, one whole read at a time.
//   state    | meaning
//   S_IDLE   | no grant; arbitrate among requesting sources
//   S_STREAM | granted source streams bases into the datapath register
//   S_DRAIN  | read closed; wait for the last base to leave, then report it
module read_scheduler
    import proj_pkg::*;
#(
    parameter int NUM_SRC      = DEF_NUM_SRC,
    parameter int MAX_READ_LEN = DEF_MAX_READ_LEN
) (
    input logic             clk,
    input logic             rst_n,
    read_scheduler_if.slave bus
);
    localparam int ID_W  = id_w(NUM_SRC);
    localparam int LEN_W = $clog2(MAX_READ_LEN + 1);

    sched_state_t        r_state, w_next;
    logic [ID_W-1:0]     r_grant, r_rr_ptr, r_read_src, w_arb_idx;
    logic [NUM_SRC-1:0]  r_grant_oh, w_arb_gnt;
    logic [LEN_W-1:0]    r_cnt, r_read_len;
    logic [BASE_LEN-1:0] r_dp_data;
    logic                r_dp_valid, r_busy, r_read_done, r_err;
    logic                w_arb_any, w_ready_g, w_xfer, w_consume;
    logic                w_hit_max, w_end_read, w_drain_done;

    rr_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_arb (
        .i_req (bus.src_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // The datapath register can take a new base when empty or being emptied.
    assign w_ready_g    = (r_state == S_STREAM) && (!r_dp_valid || !bus.dp_wait);
    assign w_xfer       = w_ready_g && bus.src_valid[r_grant];
    assign w_consume    = r_dp_valid && !bus.dp_wait;
    assign w_hit_max    = (r_cnt == LEN_W'(MAX_READ_LEN - 1));
    assign w_end_read   = w_xfer && (bus.src_last[r_grant] || w_hit_max);
    assign w_drain_done = (r_state == S_DRAIN) && (!r_dp_valid || w_consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_arb_any)    w_next = S_STREAM;
            S_STREAM: if (w_end_read)   w_next = S_DRAIN;
            S_DRAIN:  if (w_drain_done) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.src_ready = w_ready_g ? r_grant_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_grant_oh  <= '0;
            r_rr_ptr    <= ID_W'(NUM_SRC - 1);
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_read_done <= 1'b0;
            r_read_src  <= '0;
            r_read_len  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_read_done <= 1'b0;
            if (r_state == S_IDLE && w_arb_any) begin
                r_grant    <= w_arb_idx;
                r_grant_oh <= w_arb_gnt;
                r_busy     <= 1'b1;
                r_cnt      <= '0;
            end
            if (w_xfer) r_cnt <= r_cnt + 1'b1;
            // Truncated read: the rest of the source's bases form a later read.
            if (w_xfer && w_hit_max && !bus.src_last[r_grant]) r_err <= 1'b1;
            if (w_drain_done) begin
                r_read_done <= 1'b1;
                r_read_src  <= r_grant;
                r_read_len  <= r_cnt;
                r_rr_ptr    <= r_grant;
                r_busy      <= 1'b0;
                r_grant_oh  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_data  <= '0;
            r_dp_valid <= 1'b0;
        end else if (w_xfer) begin
            r_dp_data  <= bus.src_data[r_grant];
            r_dp_valid <= 1'b1;
        end else if (w_consume) begin
            r_dp_valid <= 1'b0;
        end
    end

    assign bus.dp_in_data   = r_dp_data;
    assign bus.dp_in_valid  = r_dp_valid;
    assign bus.grant_id     = r_grant;
    assign bus.busy         = r_busy;
    assign bus.read_done    = r_read_done;
    assign bus.read_src     = r_read_src;
    assign bus.read_len     = r_read_len;
    assign bus.err_overflow = r_err;
endmodule

// File: tb/tb_read_scheduler.sv
// Scoreboard bench for read_scheduler with NUM_SRC=4, MAX_READ_LEN=8.
// Drivers queue expected bases per source; a negedge monitor checks the datapath side.
module tb_read_scheduler;
    import proj_pkg::*;

    localparam int NS = 4;
    localparam int ML = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    read_scheduler_if #(.NUM_SRC(NS), .MAX_READ_LEN(ML)) bus();
    read_scheduler #(.NUM_SRC(NS), .MAX_READ_LEN(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic                v [NS];
    logic [BASE_LEN-1:0] d [NS];
    logic                l [NS];
    logic                dp_wait;
    int                  seq [NS];

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bus.src_valid[i] = v[i];
            bus.src_data[i]  = d[i];
            bus.src_last[i]  = l[i];
        end
        bus.dp_wait = dp_wait;
    end

    logic [BASE_LEN-1:0] exp_data [NS][$];
    int exp_rsrc [$];
    int exp_rlen [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_read(input int s, input int len);
        exp_rsrc.push_back(s);
        exp_rlen.push_back(len);
    endtask

    // Sends n bases from source s; optional valid gap after base gap_idx.
    task automatic send_read(input int s, input int n, input bit last_end,
                             input int gap_idx, input int gap_len);
        logic [BASE_LEN-1:0] b;
        bit hs;
        int t;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            b = {s[1:0], seq[s][5:0]};
            seq[s]++;
            exp_data[s].push_back(b);
            v[s] = 1'b1;
            d[s] = b;
            l[s] = last_end && (k == n - 1);
            hs = 1'b0;
            t = 0;
            while (!hs) begin
                @(negedge clk);
                hs = bus.src_ready[s];
                @(posedge clk); #1;
                t++;
                if (!hs && t > 300) begin
                    fail("handshake_timeout");
                    v[s] = 1'b0;
                    l[s] = 1'b0;
                    return;
                end
            end
            if (k == gap_idx) begin
                v[s] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        v[s] = 1'b0;
        l[s] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((exp_rsrc.size() != 0 || bus.busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) fail("done_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Monitor: base order, load latency, stall hold, read completion.
    initial begin : monitor
        logic                pend, hold;
        logic [BASE_LEN-1:0] pend_data, hold_data;
        int                  g;
        pend = 1'b0;
        hold = 1'b0;
        pend_data = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                hold = 1'b0;
            end else begin
                if (pend) begin
                    check("load_valid", 32'(bus.dp_in_valid), 32'd1);
                    check("load_data", 32'(bus.dp_in_data), 32'(pend_data));
                end
                if (hold) begin
                    check("stall_valid", 32'(bus.dp_in_valid), 32'd1);
                    check("stall_data", 32'(bus.dp_in_data), 32'(hold_data));
                end
                if (bus.dp_in_valid && bus.dp_wait)
                    check("ready_in_stall", 32'(bus.src_ready), 32'd0);
                if (bus.dp_in_valid && !bus.dp_wait) begin
                    g = int'(bus.grant_id);
                    if (exp_data[g].size() == 0) fail("extra_base");
                    else check("base_order", 32'(bus.dp_in_data), 32'(exp_data[g].pop_front()));
                end
                if (bus.read_done) begin
                    if (exp_rsrc.size() == 0) fail("extra_read_done");
                    else begin
                        check("read_src", 32'(bus.read_src), 32'(exp_rsrc.pop_front()));
                        check("read_len", 32'(bus.read_len), 32'(exp_rlen.pop_front()));
                    end
                end
                pend = 1'b0;
                for (int s = 0; s < NS; s++) begin
                    if (v[s] && bus.src_ready[s]) begin
                        pend = 1'b1;
                        pend_data = d[s];
                    end
                end
                hold = bus.dp_in_valid && bus.dp_wait;
                hold_data = bus.dp_in_data;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_dp_valid"}, 32'(bus.dp_in_valid), 32'd0);
        check({tag, "_dp_data"}, 32'(bus.dp_in_data), 32'd0);
        check({tag, "_src_ready"}, 32'(bus.src_ready), 32'd0);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
        check({tag, "_read_done"}, 32'(bus.read_done), 32'd0);
        check({tag, "_read_src"}, 32'(bus.read_src), 32'd0);
        check({tag, "_read_len"}, 32'(bus.read_len), 32'd0);
        check({tag, "_err"}, 32'(bus.err_overflow), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
            l[i] = 1'b0;
            seq[i] = 0;
        end
        dp_wait = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // All four request: round-robin 0,1,2,3 then 0 again.
        push_read(0, 2); push_read(1, 2); push_read(2, 2); push_read(3, 2); push_read(0, 2);
        fork
            begin send_read(0, 2, 1'b1, -1, 0); send_read(0, 2, 1'b1, -1, 0); end
            send_read(1, 2, 1'b1, -1, 0);
            send_read(2, 2, 1'b1, -1, 0);
            send_read(3, 2, 1'b1, -1, 0);
        join
        wait_done(300);

        // Source 2, five bases, no backpressure.
        push_read(2, 5);
        send_read(2, 5, 1'b1, -1, 0);
        wait_done(200);
        check("err_after_normal", 32'(bus.err_overflow), 32'd0);

        // Source 3 with a 3-cycle stall and a valid gap mid-read.
        push_read(3, 6);
        fork
            send_read(3, 6, 1'b1, 3, 2);
            begin
                repeat (3) @(posedge clk);
                #1 dp_wait = 1'b1;
                repeat (3) @(posedge clk);
                #1 dp_wait = 1'b0;
            end
        join
        wait_done(200);

        // Source 1, ten bases: truncated at 8, remainder is a 2-base read.
        push_read(1, 8); push_read(1, 2);
        send_read(1, 10, 1'b1, -1, 0);
        wait_done(300);
        check("err_overflow_set", 32'(bus.err_overflow), 32'd1);
        repeat (3) @(negedge clk);
        check("read_src_hold", 32'(bus.read_src), 32'd1);
        check("read_len_hold", 32'(bus.read_len), 32'd2);
        check("err_sticky", 32'(bus.err_overflow), 32'd1);

        // Reset in the middle of a read from source 2 after three bases.
        send_read(2, 3, 1'b0, -1, 0);
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        check("reset_no_done", 32'(bus.read_done), 32'd0);
        exp_data[2].delete();
        rst_n = 1'b1;

        // Pointer back to NUM_SRC-1: source 0 must beat source 2.
        push_read(0, 1); push_read(2, 1);
        fork
            send_read(0, 1, 1'b1, -1, 0);
            send_read(2, 1, 1'b1, -1, 0);
        join
        wait_done(200);

        for (int s = 0; s < NS; s++)
            check($sformatf("leftover_bases_src%0d", s), 32'(exp_data[s].size()), 32'd0);
        check("leftover_reads", 32'(exp_rsrc.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/read_scheduler.md
READ_SCHEDULER -- requirements
Module: read_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of read sources sharing one proj_top datapath.
REQ-002 SHALL have parameter MAX_READ_LEN, default 256, maximum bases per granted read.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have src_valid  in  NUM_SRC  per-source base valid.
REQ-005 SHALL have src_data  in  NUM_SRC x proj_pkg::BASE_LEN  per-source base.
REQ-006 SHALL have src_last  in  NUM_SRC  per-source last-base-of-read flag.
REQ-007 SHALL have src_ready  out  NUM_SRC  per-source accept.
REQ-008 SHALL have dp_in_data  out  BASE_LEN  base to proj_top in_data.
REQ-009 SHALL have dp_in_valid  out  1  dp_in_data holds an unconsumed base.
REQ-010 SHALL have dp_wait  in  1  proj_top out_wait; high = datapath stalled.
REQ-011 SHALL have grant_id  out  SRC_ID_W  currently granted source.
REQ-012 SHALL have busy  out  1  a read is in progress.
REQ-013 SHALL have read_done  out  1  one-cycle pulse at end of read.
REQ-014 SHALL have read_src  out  SRC_ID_W  source of the completed read, valid with read_done.
REQ-015 SHALL have read_len  out  $clog2(MAX_READ_LEN+1)  bases in the completed read.
REQ-016 SHALL have err_overflow  out  1  sticky: a read was truncated at MAX_READ_LEN.

Function
REQ-017 SHALL implement FSM IDLE -> STREAM -> DRAIN -> IDLE.
REQ-018 IDLE: if any src_valid, SHALL pick a winner round-robin starting at rr_ptr+1 (mod NUM_SRC), register grant_id, set busy, go STREAM next cycle; else stay.
REQ-019 STREAM: src_ready[grant_id] SHALL equal (!dp_in_valid || !dp_wait); all other src_ready SHALL be 0; outside STREAM all src_ready SHALL be 0.
REQ-020 Transfer = src_valid & src_ready on grant_id; SHALL load dp_in_data and set dp_in_valid on the next edge (1-cycle latency).
REQ-021 Datapath consume = dp_in_valid & !dp_wait; dp_in_data SHALL be held stable while dp_in_valid & dp_wait.
REQ-022 Simultaneous consume and transfer SHALL keep dp_in_valid=1 with new data (no bubble); consume without transfer SHALL clear dp_in_valid.
REQ-023 Length counter SHALL clear on grant and increment per transfer.
REQ-024 Transfer with src_last SHALL go DRAIN.
REQ-025 Transfer making count = MAX_READ_LEN without src_last SHALL set err_overflow and go DRAIN; remaining bases are a new read later.
REQ-026 Granted source deasserting src_valid mid-read SHALL keep the grant (no timeout, no preemption).
REQ-027 DRAIN: once dp_in_valid is 0 (or consumed that cycle), SHALL pulse read_done with read_src=grant_id, read_len=count, set rr_ptr=grant_id, clear busy, go IDLE.
REQ-028 read_src/read_len SHALL hold their value until the next read_done.
REQ-029 err_overflow SHALL clear only on reset.

Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE, rr_ptr=NUM_SRC-1 (source 0 wins first), all outputs 0, counter 0; an in-flight read is discarded with no read_done.

Structure
REQ-031 proj_pkg SHALL hold sched_state_t enum, default NUM_SRC, MAX_READ_LEN and SRC_ID_W=$clog2(NUM_SRC); BASE_LEN reused from proj_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, rr_ptr -> one-hot grant + index).

Verification (NUM_SRC=4, MAX_READ_LEN=8)
REQ-033 After reset, src_valid=4'b1111 -> grants in order 0,1,2,3,0 with one read_done per read.
REQ-034 Source 2 sends 5 bases (last on 5th), dp_wait=0 -> bases on dp_in_data in order, 1 cycle after each transfer; read_done with read_src=2, read_len=5.
REQ-035 dp_wait high 3 cycles mid-read -> dp_in_data stable, src_ready=0 while dp_in_valid, no base lost or duplicated.
REQ-036 Source 1 sends 10 bases without last -> read_len=8, err_overflow=1, next grant of source 1 gives read_len=2.
REQ-037 rst_n low during STREAM after 3 bases -> all outputs 0 asynchronously, no read_done, next grant is source 0.
